ex_mem_pipe: RTL and testbench

Elastic EX→MEM pipeline stage that replaces the fixed EX/MEM register with a parametrised, two-entry skid buffer. It uses valid/ready handshakes on both sides and supports stall, flush, and x0-write suppression. It sits between the execute stage and the data-memory stage and sustains one instruction per cycle when MEM never back-pressures.

---
 rtl/ex_mem_pkg.sv | 26 ++
 rtl/pipe_skid_buf.sv | 76 +++++++
 rtl/ex_mem_pipe.sv | 106 ++++++++++
 tb/tb_ex_mem_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - EX/MEM entry field widths, control bit positions and packed payload offsets
package ex_mem_pkg;

    localparam int CTRL_W         = 4;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_BRANCH    = 3;

    localparam int PC_W      = 15;
    localparam int DATA_W    = 16;
    localparam int REGADDR_W = 4;

    // Packed entry layout, LSB first: rd, write_data, alu_result, pc, ctrl
    localparam int RD_LSB    = 0;
    localparam int WDATA_LSB = RD_LSB + REGADDR_W;
    localparam int ALU_LSB   = WDATA_LSB + DATA_W;
    localparam int PC_LSB    = ALU_LSB + DATA_W;
    localparam int CTRL_LSB  = PC_LSB + PC_W;
    localparam int ENTRY_W   = CTRL_LSB + CTRL_W;

    function automatic int entry_width(input int pc_w, input int data_w, input int regaddr_w);
        return CTRL_W + pc_w + 2 * data_w + regaddr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic two-entry valid/ready skid buffer with flush and registered ready
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_skid_valid,
    output logic [WIDTH-1:0] o_skid_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_accept;
    logic w_retire;
    logic w_main_free;
    logic w_skid_valid_next;

    assign w_accept    = i_valid && r_ready;
    assign w_retire    = r_main_valid && i_ready;
    assign w_main_free = !r_main_valid || w_retire;

    // A free main slot drains the skid first, so an incoming beat only lands in the skid if one is already there.
    always_comb begin
        w_skid_valid_next = 1'b0;
        if (!i_flush) begin
            if (w_main_free)
                w_skid_valid_next = r_skid_valid && w_accept;
            else
                w_skid_valid_next = r_skid_valid || w_accept;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_ready      <= !w_skid_valid_next;
            r_skid_valid <= w_skid_valid_next;
            if (i_flush)
                r_main_valid <= 1'b0;
            else if (w_main_free)
                r_main_valid <= r_skid_valid || w_accept;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_flush && w_main_free) begin
            if (r_skid_valid)
                r_main_data <= r_skid_data;
            else if (w_accept)
                r_main_data <= i_data;
        end
        if (!i_flush && w_accept && (r_skid_valid || !w_main_free))
            r_skid_data <= i_data;
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_main_valid;
    assign o_data       = r_main_data;
    assign o_skid_valid = r_skid_valid;
    assign o_skid_data  = r_skid_data;

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - elastic EX->MEM stage over pipe_skid_buf; EX_MEM_FWD_EN adds fwd0/fwd1 bypass ports
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int PC_WIDTH      = PC_W,
    parameter int DATA_WIDTH    = DATA_W,
    parameter int REGADDR_WIDTH = REGADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic                     ex_branch,
    input  logic [PC_WIDTH-1:0]      ex_pc,
    input  logic [DATA_WIDTH-1:0]    ex_alu_result,
    input  logic [DATA_WIDTH-1:0]    ex_reg_data2,
    input  logic [REGADDR_WIDTH-1:0] ex_rd,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_reg_write,
    output logic                     mem_mem_read,
    output logic                     mem_mem_write,
    output logic                     mem_branch,
    output logic [PC_WIDTH-1:0]      mem_pc,
    output logic [DATA_WIDTH-1:0]    mem_alu_result,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
`ifdef EX_MEM_FWD_EN
    output logic [REGADDR_WIDTH-1:0] mem_rd,
    output logic                     fwd0_valid,
    output logic [REGADDR_WIDTH-1:0] fwd0_rd,
    output logic [DATA_WIDTH-1:0]    fwd0_data,
    output logic                     fwd1_valid,
    output logic [REGADDR_WIDTH-1:0] fwd1_rd,
    output logic [DATA_WIDTH-1:0]    fwd1_data
`else
    output logic [REGADDR_WIDTH-1:0] mem_rd
`endif
);

    localparam int L_RD_LSB    = 0;
    localparam int L_WDATA_LSB = L_RD_LSB + REGADDR_WIDTH;
    localparam int L_ALU_LSB   = L_WDATA_LSB + DATA_WIDTH;
    localparam int L_PC_LSB    = L_ALU_LSB + DATA_WIDTH;
    localparam int L_CTRL_LSB  = L_PC_LSB + PC_WIDTH;
    localparam int L_ENTRY_W   = entry_width(PC_WIDTH, DATA_WIDTH, REGADDR_WIDTH);

    logic [CTRL_W-1:0]    w_in_ctrl;
    logic [L_ENTRY_W-1:0] w_in_entry;
    logic                 w_main_valid;
    logic [L_ENTRY_W-1:0] w_main_entry;
    logic                 w_skid_valid;
    logic [L_ENTRY_W-1:0] w_skid_entry;
    logic                 w_ready;

    // Writes to x0 are squashed at capture so nothing downstream has to re-check rd.
    assign w_in_ctrl  = {ex_branch, ex_mem_write, ex_mem_read, ex_reg_write && (ex_rd != '0)};
    assign w_in_entry = {w_in_ctrl, ex_pc, ex_alu_result, ex_reg_data2, ex_rd};

    pipe_skid_buf #(
        .WIDTH(L_ENTRY_W)
    ) u_skid_buf (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_flush     (flush),
        .i_valid     (ex_valid),
        .o_ready     (w_ready),
        .i_data      (w_in_entry),
        .o_valid     (w_main_valid),
        .i_ready     (mem_ready),
        .o_data      (w_main_entry),
        .o_skid_valid(w_skid_valid),
        .o_skid_data (w_skid_entry)
    );

    assign ex_ready  = w_ready;
    assign mem_valid = w_main_valid;

    // Payload is gated too so an empty stage (including just after reset) presents all zeros.
    assign mem_reg_write  = w_main_valid && w_main_entry[L_CTRL_LSB + CTRL_REG_WRITE];
    assign mem_mem_read   = w_main_valid && w_main_entry[L_CTRL_LSB + CTRL_MEM_READ];
    assign mem_mem_write  = w_main_valid && w_main_entry[L_CTRL_LSB + CTRL_MEM_WRITE];
    assign mem_branch     = w_main_valid && w_main_entry[L_CTRL_LSB + CTRL_BRANCH];
    assign mem_pc         = w_main_valid ? w_main_entry[L_PC_LSB +: PC_WIDTH] : '0;
    assign mem_alu_result = w_main_valid ? w_main_entry[L_ALU_LSB +: DATA_WIDTH] : '0;
    assign mem_write_data = w_main_valid ? w_main_entry[L_WDATA_LSB +: DATA_WIDTH] : '0;
    assign mem_rd         = w_main_valid ? w_main_entry[L_RD_LSB +: REGADDR_WIDTH] : '0;

`ifdef EX_MEM_FWD_EN
    assign fwd0_valid = w_main_valid && w_main_entry[L_CTRL_LSB + CTRL_REG_WRITE]
                        && !w_main_entry[L_CTRL_LSB + CTRL_MEM_READ];
    assign fwd0_rd    = w_main_entry[L_RD_LSB +: REGADDR_WIDTH];
    assign fwd0_data  = w_main_entry[L_ALU_LSB +: DATA_WIDTH];
    assign fwd1_valid = w_skid_valid && w_skid_entry[L_CTRL_LSB + CTRL_REG_WRITE]
                        && !w_skid_entry[L_CTRL_LSB + CTRL_MEM_READ];
    assign fwd1_rd    = w_skid_entry[L_RD_LSB +: REGADDR_WIDTH];
    assign fwd1_data  = w_skid_entry[L_ALU_LSB +: DATA_WIDTH];
`else
    logic w_unused_skid;
    assign w_unused_skid = ^{w_skid_valid, w_skid_entry};
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - table-driven directed bench for ex_mem_pipe
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [14:0] ex_pc;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_reg_data2;
    logic [3:0]  ex_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
    logic [14:0] mem_pc;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_write_data;
    logic [3:0]  mem_rd;
`ifdef EX_MEM_FWD_EN
    logic        fwd0_valid, fwd1_valid;
    logic [3:0]  fwd0_rd, fwd1_rd;
    logic [15:0] fwd0_data, fwd1_data;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_pc         (ex_pc),
        .ex_alu_result (ex_alu_result),
        .ex_reg_data2  (ex_reg_data2),
        .ex_rd         (ex_rd),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_branch    (mem_branch),
        .mem_pc        (mem_pc),
        .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data),
`ifdef EX_MEM_FWD_EN
        .mem_rd        (mem_rd),
        .fwd0_valid    (fwd0_valid),
        .fwd0_rd       (fwd0_rd),
        .fwd0_data     (fwd0_data),
        .fwd1_valid    (fwd1_valid),
        .fwd1_rd       (fwd1_rd),
        .fwd1_data     (fwd1_data)
`else
        .mem_rd        (mem_rd)
`endif
    );

    typedef struct {
        logic fl;
        logic v;
        int   pc;
        logic mr;
        logic er;
        logic mv;
        int   epc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, input logic v, input int pc, input logic mr,
                       input logic er, input logic mv, input int epc);
        vec_t e;
        e.fl = fl; e.v = v; e.pc = pc; e.mr = mr; e.er = er; e.mv = mv; e.epc = epc;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat k: pc=k, alu=k*3, store data=k*5+7, rd=k[3:0], ctrl from low pc bits, reg_write requested.
    task automatic drive_beat(input logic fl, input logic v, input int pc, input logic mr);
        logic [31:0] p;
        p = pc;
        flush         = fl;
        ex_valid      = v;
        mem_ready     = mr;
        ex_pc         = 15'(pc);
        ex_alu_result = 16'(pc * 3);
        ex_reg_data2  = 16'(pc * 5 + 7);
        ex_rd         = 4'(pc);
        ex_reg_write  = 1'b1;
        ex_mem_read   = p[0];
        ex_mem_write  = p[1];
        ex_branch     = p[2];
    endtask

    function automatic logic [63:0] expect_out(input logic er, input logic mv, input int pc);
        logic [31:0] p;
        logic [3:0]  rd;
        p  = pc;
        rd = 4'(pc);
        if (!mv)
            return {7'b0, er, 1'b0, 55'b0};
        return {7'b0, er, 1'b1, p[2], p[1], p[0], rd != 4'd0,
                15'(pc), 16'(pc * 3), 16'(pc * 5 + 7), rd};
    endfunction

    function automatic logic [63:0] sample_out();
        return {7'b0, ex_ready, mem_valid, mem_branch, mem_mem_write, mem_mem_read, mem_reg_write,
                mem_pc, mem_alu_result, mem_write_data, mem_rd};
    endfunction

    initial begin
        logic [63:0] act;
        logic [63:0] exp;

        reset = 1'b1;
        drive_beat(1'b0, 1'b0, 0, 1'b0);
        ex_reg_write = 1'b0;

        // Stream of eight beats with no back-pressure
        for (int k = 0; k < 8; k++) add(0, 1, k, 1, 1, 1, k);
        add(0, 0, 0, 1, 1, 0, 0);
        // Back-pressure for three cycles: 8 in main, 9 in skid, 10 waits
        add(0, 1, 8,  1, 1, 1, 8);
        add(0, 1, 9,  0, 0, 1, 8);
        add(0, 1, 10, 0, 0, 1, 8);
        add(0, 1, 10, 0, 0, 1, 8);
        add(0, 1, 10, 1, 1, 1, 9);
        add(0, 1, 10, 1, 1, 1, 10);
        add(0, 1, 11, 1, 1, 1, 11);
        add(0, 0, 0,  1, 1, 0, 0);
        // Flush with both entries full and a beat offered
        add(0, 1, 12, 0, 1, 1, 12);
        add(0, 1, 13, 0, 0, 1, 12);
        add(1, 1, 14, 1, 1, 0, 0);
        add(0, 0, 0,  1, 1, 0, 0);
        add(0, 1, 15, 1, 1, 1, 15);
        add(0, 1, 16, 1, 1, 1, 16);
        add(1, 1, 17, 1, 1, 0, 0);
        add(0, 0, 0,  1, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", sample_out(), {7'b0, 1'b1, 56'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive_beat(tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].mr);
            @(posedge clk);
            #1;
            exp = expect_out(tbl[i].er, tbl[i].mv, tbl[i].epc);
            act = sample_out();
            if (!tbl[i].mv)
                act = act & 64'hFFF8_0000_0000_0000;
            check($sformatf("row%0d", i), act, exp);
        end

        // x0 destination with reg_write requested
        drive_beat(1'b0, 1'b1, 0, 1'b1);
        ex_alu_result = 16'h1234;
        @(posedge clk);
        #1;
        check("x0_reg_write", {62'b0, mem_valid, mem_reg_write}, {62'b0, 1'b1, 1'b0});
        check("x0_alu", {48'b0, mem_alu_result}, {48'b0, 16'h1234});
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        check("x0_drain", {62'b0, mem_valid, ex_ready}, {62'b0, 1'b0, 1'b1});

`ifdef EX_MEM_FWD_EN
        drive_beat(1'b0, 1'b1, 0, 1'b0);
        ex_rd = 4'd5; ex_alu_result = 16'hAAAA; ex_reg_write = 1'b1; ex_mem_read = 1'b0;
        @(posedge clk);
        #1;
        ex_rd = 4'd5; ex_alu_result = 16'hBBBB; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        check("fwd_pair", {42'b0, fwd0_valid, fwd0_rd, fwd0_data, fwd1_valid},
              {42'b0, 1'b1, 4'd5, 16'hAAAA, 1'b0});
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fwd_flush", {62'b0, fwd0_valid, fwd1_valid}, 64'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
